dmem_responder: RTL

Data-memory responder for the RISC-V core: the far end of the load/store interface whose lw/sw requests the core's control logic issues. It accepts one word request at a time over a valid/ready handshake and stalls for a programmable number of wait cycles. It then performs the write or read against an internal word array and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory so that the multicycle/pipelined core can be exercised against a slow memory.

---
 rtl/dmem_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Data-memory responder for the RISC-V core. It accepts one word load/store
// request over a valid/ready handshake and waits LATENCY cycles. It then
// commits the access against an internal word array and presents the
// response over a second valid/ready handshake until the core takes it.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 4)
//   LATENCY     : wait cycles between acceptance and response (0..15)
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   reset_n    in   asynchronous active-low reset (memory is not cleared)
//   req_valid  in   request present
//   req_ready  out  responder can accept a request (only in IDLE)
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address; word index is addr[$clog2(DEPTH)+1:2]
//   req_wdata  in   store data
//   rsp_valid  out  response present (only in RESP)
//   rsp_ready  in   core accepts response
//   rsp_rdata  out  load data, 0 for stores
//   rsp_err    out  misaligned-access flag
//
// Optional feature macro: DMEM_MISALIGN_ERR_EN
//   defined   : addr[1:0] != 0 raises rsp_err, suppresses the store and
//               returns 0 for the load; timing is unchanged.
//   undefined : addr[1:0] is ignored and rsp_err is always 0.

module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IdxW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;
  logic              commit;
  logic              suppress;
  logic              memWe;
  logic              unusedAddr;

  logic [31:0]       mem_q [DEPTH_WORDS];

  assign accept = (state_q == IDLE) && req_valid;
  // The access commits on the edge that leaves WAIT. A request therefore
  // always spends at least one cycle in WAIT, which places rsp_valid one
  // cycle after acceptance even when LATENCY is zero.
  assign commit = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_MISALIGN_ERR_EN
  logic mis_q, mis_d;

  assign suppress   = mis_q;
  assign mis_d      = accept ? (req_addr[1:0] != 2'b00) : mis_q;
  assign unusedAddr = ^req_addr[31:IdxW+2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end
`else
  assign suppress   = 1'b0;
  assign unusedAddr = ^{req_addr[31:IdxW+2], req_addr[1:0]};
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)        state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0)    state_d = RESP;
      RESP:    if (rsp_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Handshake outputs come straight from the registered state.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Request latch, wait counter and response data.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = LatCnt;
      we_d    = req_we;
      idx_d   = req_addr[IdxW+1:2];
      wdata_d = req_wdata;
    end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (commit) begin
      rdata_d = (we_q || suppress) ? 32'd0 : mem_q[idx_q];
      err_d   = suppress;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Word array keeps its contents across reset; a store only lands on its
  // commit edge, so a reset during WAIT drops it.
  assign memWe = commit && we_q && !suppress;

  always_ff @(posedge clk) begin
    if (memWe) mem_q[idx_q] <= wdata_q;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
